add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and sequencer that shares a single WIDTH-bit carry-lookahead adder between two requesters, e.g. the execute-stage ALU and the address/branch-target path. It accepts requests over valid/ready handshakes, registers the operands, performs add or subtract through the shared adder, and returns a registered result with N/Z/V flags and a requester ID on one shared response channel. Throughput is one operation per cycle when the response channel is not stalled.

## Interface
- WIDTH, 16, operand/result width; a multiple of 4 so the adder is built from 4-bit CLA groups.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0's operation is accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_sub  input  1  1 = A−B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as above, for requester 1.
- rsp_valid  output  1  result register holds an unconsumed result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_id  output  1  requester that issued the result (0 or 1).
- rsp_sum  output  WIDTH  A+B or A−B, modulo 2^WIDTH.
- rsp_n, rsp_z, rsp_v  output  1  negative (sum MSB), zero (sum == 0), signed overflow.

## Operation
- States:
  - EMPTY: no result held.
  - FULL: result held, rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready.
- Grant rules, evaluated only when can_accept=1:
  - Exactly one reqX_valid: grant X.
  - Both valid: grant the requester not granted last, per the 1-bit pointer `last`.
  - reqX_ready = can_accept & grant==X, combinational. At most one ready is high per cycle.
- On accept (reqX_valid & reqX_ready):
  - Operands feed the shared adder as A, B^{WIDTH{sub}}, carry-in=sub.
  - Sum and flags are captured into the result registers at the edge, with rsp_id=X, state→FULL, last←X.
- No accept while can_accept=1: FULL→EMPTY if rsp_ready, else stay EMPTY.
- FULL & !rsp_ready: hold all rsp_* stable and force both readys to 0.
- Arithmetic:
  - Bsel = sub ? ~B : B.
  - sum = A + Bsel + sub, truncated to WIDTH.
  - v = (A[MSB]==Bsel[MSB]) & (sum[MSB]!=A[MSB]).
  - n = sum[MSB]; z = (sum==0).
  - Carry-out is not reported.
- The adder is 4-bit CLA groups with group p/g combined by lookahead logic. It is purely combinational between the operand mux and the result register.
- A request is never dropped or duplicated. A requester whose valid stays high is granted within 2 accept opportunities.
- reqX_valid may drop without being accepted; the arbiter holds no pending state for it.

## Timing
- Reset (asynchronous, immediate):
  - state=EMPTY, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_n=0, rsp_z=0, rsp_v=0.
  - last=1, so requester 0 wins the first contention.
  - req0_ready/req1_ready follow combinationally: high to a valid requester once rst deasserts.
- Latency: accept at edge k gives rsp_valid=1 with the result from edge k onward (1 cycle, registered).
- Back-to-back: rsp_ready=1 and a new accept in the same cycle gives the old result consumed and the new result loaded at the same edge; rsp_valid stays 1.
- Readys depend combinationally on reqX_valid, rsp_ready, state and last. No req-to-ready path passes through the adder.
- Reset mid-operation clears any held result; the pending result is lost. Requesters must re-issue.
- Critical path: operand mux → CLA → zero-detect → result register; must close in one cycle.

## Test plan
- Reset with both valids high → after rst falls: req0_ready=1, req1_ready=0. Accept 0x0003+0x0004 → next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x0007, n=z=v=0.
- Continuous contention, rsp_ready=1 → grants alternate 0,1,0,1 each cycle; rsp_valid stays 1 and rsp_id alternates. Requester 1 with sub=1, 0x0005−0x0005 → sum=0x0000, z=1.
- Overflow/negative:
  - 0x7FFF+0x0001 → sum=0x8000, n=1, v=1.
  - 0x8000−0x0001 → sum=0x7FFF, v=1, n=0.
  - 0xFFFF+0x0001 → sum=0x0000, z=1, v=0.
- Backpressure: rsp_ready=0 for 3 cycles with both valids high → readys 0, rsp_* stable. Raise rsp_ready → the held result is consumed and the next grant goes to the requester not granted last, in the same cycle.
- Reset asserted while FULL with rsp_ready=0 → rsp_valid and rsp_sum drop to 0 immediately, without waiting for a clock edge; after release, requester 0 wins contention.
- Random operands and sub values on both requesters with random rsp_ready, checked against a reference model → every accepted request yields exactly one response in order, with the correct id, sum and flags.

Source files
------------

// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request and response channels of the shared-adder arbiter
interface add_arbiter_if #(parameter int WIDTH = 16);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_n;
  logic             rsp_z;
  logic             rsp_v;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_n, rsp_z, rsp_v
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_n, rsp_z, rsp_v
  );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one CLA adder between two requesters
module add_arbiter #(parameter int WIDTH = 16) (
  input logic         clk,
  input logic         rst,
  add_arbiter_if.slave bus
);
  localparam int NG = WIDTH / 4;
  localparam int M = WIDTH - 1;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           r_state, w_state_nxt;
  logic             r_last, r_id, r_n, r_z, r_v;
  logic [WIDTH-1:0] r_sum;
  logic             w_can, w_gnt, w_acc, w_sub;
  logic [WIDTH-1:0] w_a, w_bsel, w_p, w_g, w_c, w_sum;
  logic [NG-1:0]    w_gc;
  // Grant never depends on operands, so ready stays off the adder path.
  assign w_can = (r_state == EMPTY) | bus.rsp_ready;
  assign w_gnt = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
  assign bus.req0_ready = w_can & ~w_gnt;
  assign bus.req1_ready = w_can & w_gnt;
  assign w_acc = w_can & (w_gnt ? bus.req1_valid : bus.req0_valid);
  assign w_a = w_gnt ? bus.req1_a : bus.req0_a;
  assign w_sub = w_gnt ? bus.req1_sub : bus.req0_sub;
  assign w_bsel = (w_gnt ? bus.req1_b : bus.req0_b) ^ {WIDTH{w_sub}};
  assign w_p = w_a ^ w_bsel;
  assign w_g = w_a & w_bsel;
  assign w_gc[0] = w_sub;
  for (genvar k = 0; k < NG; k++) begin : g_cla
    logic [3:0] w_gp, w_gg;
    logic       w_ci;
    assign w_gp = w_p[4*k +: 4];
    assign w_gg = w_g[4*k +: 4];
    assign w_ci = w_gc[k];
    assign w_c[4*k]   = w_ci;
    assign w_c[4*k+1] = w_gg[0] | (w_gp[0] & w_ci);
    assign w_c[4*k+2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & w_ci);
    assign w_c[4*k+3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0]) | (&w_gp[2:0] & w_ci);
    if (k < NG - 1) begin : g_next
      assign w_gc[k+1] = w_gg[3] | (w_gp[3] & w_gg[2]) | (&w_gp[3:2] & w_gg[1])
                       | (&w_gp[3:1] & w_gg[0]) | (&w_gp & w_ci);
    end
  end
  assign w_sum = w_p ^ w_c;
  // State register: FULL whenever the result register holds an unconsumed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end
  // Next state: a new accept refills, otherwise a consumed result empties.
  always_comb begin
    w_state_nxt = w_acc ? FULL : (w_can ? EMPTY : r_state);
  end
  // Result capture with flags; last points at the most recent winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_sum  <= '0;
      r_n    <= 1'b0;
      r_z    <= 1'b0;
      r_v    <= 1'b0;
    end else if (w_acc) begin
      r_last <= w_gnt;
      r_id   <= w_gnt;
      r_sum  <= w_sum;
      r_n    <= w_sum[M];
      r_z    <= (w_sum == '0);
      r_v    <= (w_a[M] == w_bsel[M]) & (w_sum[M] != w_a[M]);
    end
  end
  assign bus.rsp_valid = (r_state == FULL);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_n     = r_n;
  assign bus.rsp_z     = r_z;
  assign bus.rsp_v     = r_v;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed and randomized checks of the shared-adder arbiter
module tb_add_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  add_arbiter_if #(.WIDTH(16)) bus();
  add_arbiter #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic set_req(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                         input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic s1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_sub = s0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_sub = s1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req(1, 16'h0003, 16'h0004, 0, 1, 16'h0009, 16'h0001, 0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_n, bus.rsp_z, bus.rsp_v} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b id=%b sum=%h nzv=%b%b%b, want all zero",
               bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_n, bus.rsp_z, bus.rsp_v);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_grant: got ready0/1=%b%b, want 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_n, bus.rsp_z, bus.rsp_v} !== {2'b10, 16'h0007, 3'b000}) begin
      n_fail++;
      $display("FAIL first_result: got valid=%b id=%b sum=%h nzv=%b%b%b, want 1 0 0007 000",
               bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_n, bus.rsp_z, bus.rsp_v);
    end
  endtask
  task automatic test_alternate;
    logic exp_g = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    set_req(1, 16'h0003, 16'h0004, 0, 1, 16'h0005, 16'h0005, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {~exp_g, exp_g}) begin
        n_fail++;
        $display("FAIL alt_grant[%0d]: got ready0/1=%b%b, want %b%b", i, bus.req0_ready, bus.req1_ready, ~exp_g, exp_g);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_z} !== {1'b1, exp_g, exp_g ? 16'h0000 : 16'h0007, exp_g}) begin
        n_fail++;
        $display("FAIL alt_result[%0d]: got valid=%b id=%b sum=%h z=%b, want 1 %b %h %b", i, bus.rsp_valid, bus.rsp_id,
                 bus.rsp_sum, bus.rsp_z, exp_g, exp_g ? 16'h0000 : 16'h0007, exp_g);
      end
      exp_g = ~exp_g;
      @(negedge clk);
    end
  endtask
  task automatic test_flags;
    logic [15:0] ta [3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h0001, 16'h0001, 16'h0001};
    logic        ts [3] = '{1'b0, 1'b1, 1'b0};
    logic [18:0] te [3] = '{{16'h8000, 3'b101}, {16'h7FFF, 3'b001}, {16'h0000, 3'b010}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_req(1, ta[i], tb[i], ts[i], 0, 16'h0, 16'h0, 0);
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_n, bus.rsp_z, bus.rsp_v} !== {2'b10, te[i]}) begin
        n_fail++;
        $display("FAIL flags[%0d]: got valid=%b id=%b sum=%h nzv=%b%b%b, want 1 0 %h %b", i, bus.rsp_valid, bus.rsp_id,
                 bus.rsp_sum, bus.rsp_n, bus.rsp_z, bus.rsp_v, te[i][18:3], te[i][2:0]);
      end
    end
  endtask
  task automatic test_backpressure;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(1, 16'h0001, 16'h0002, 0, 1, 16'h0010, 16'h0020, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_z} !== {4'b0010, 16'h0000, 1'b1}) begin
        n_fail++;
        $display("FAIL stall[%0d]: got ready0/1=%b%b valid=%b id=%b sum=%h z=%b, want 00 1 0 0000 1", i, bus.req0_ready,
                 bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_z);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL release_grant: got ready0/1=%b%b, want 01", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum} !== {2'b11, 16'h0030}) begin
      n_fail++;
      $display("FAIL release_result: got valid=%b id=%b sum=%h, want 1 1 0030", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
  endtask
  task automatic test_reset_full;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_sum} !== 17'h0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b sum=%h, want 0 0000", bus.rsp_valid, bus.rsp_sum);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_regrant: got ready0/1=%b%b, want 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum} !== {2'b10, 16'h0003}) begin
      n_fail++;
      $display("FAIL reset_regrant_result: got valid=%b id=%b sum=%h, want 1 0 0003", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
  endtask
  task automatic test_random;
    logic [19:0] q[$];
    logic        m_full = 1'b0;
    logic        m_last = 1'b1;
    logic        can, gnt, acc;
    logic [15:0] a, b, s;
    int          res;
    int          n_acc = 0;
    int          n_rsp = 0;
    @(negedge clk);
    set_req(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      set_req(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
              ($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom));
      if (i % 7 == 0) bus.req0_a = 16'h7FFF;
      bus.rsp_ready = ($urandom % 3) != 0;
      #1;
      can = !m_full || bus.rsp_ready;
      gnt = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {can && !gnt, can && gnt}) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got ready0/1=%b%b, want %b%b", i, bus.req0_ready, bus.req1_ready, can && !gnt, can && gnt);
      end
      n_checks++;
      if (bus.rsp_valid !== m_full) begin
        n_fail++;
        $display("FAIL rand_valid[%0d]: got %b, want %b", i, bus.rsp_valid, m_full);
      end
      if (m_full && q.size() > 0) begin
        n_checks++;
        if ({bus.rsp_id, bus.rsp_sum, bus.rsp_n, bus.rsp_z, bus.rsp_v} !== q[0]) begin
          n_fail++;
          $display("FAIL rand_rsp[%0d]: got id=%b sum=%h nzv=%b%b%b, want id=%b sum=%h nzv=%b", i, bus.rsp_id, bus.rsp_sum,
                   bus.rsp_n, bus.rsp_z, bus.rsp_v, q[0][19], q[0][18:3], q[0][2:0]);
        end
        if (bus.rsp_ready) begin
          void'(q.pop_front());
          n_rsp++;
        end
      end
      acc = can && (gnt ? bus.req1_valid : bus.req0_valid);
      if (acc) begin
        a = gnt ? bus.req1_a : bus.req0_a;
        b = gnt ? bus.req1_b : bus.req0_b;
        res = (gnt ? bus.req1_sub : bus.req0_sub) ? int'($signed(a)) - int'($signed(b))
                                                   : int'($signed(a)) + int'($signed(b));
        s = 16'(res);
        q.push_back({gnt, s, s[15], s == 16'h0, (res > 32767) || (res < -32768)});
        n_acc++;
        m_full = 1'b1;
        m_last = gnt;
      end else if (can) m_full = 1'b0;
    end
    n_checks++;
    if (n_acc - n_rsp !== int'(m_full) || q.size() !== int'(m_full)) begin
      n_fail++;
      $display("FAIL rand_count: accepts=%0d responses=%0d held=%0d, want difference equal to held", n_acc, n_rsp, m_full);
    end
  endtask
  initial begin
    test_reset;
    test_alternate;
    test_flags;
    test_backpressure;
    test_reset_full;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
